spart_rx: RTL and testbench
===========================

SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 The port list SHALL be, one per line:
  clk        input   1  system clock; all state changes on rising edge
  rst_n      input   1  reset; asynchronous assert, active low
  baud       input   1  one-clk enable pulse at 16x bit rate (divisor-based generator output)
  rxd        input   1  serial line, asynchronous to clk, idles high
  rd_ack     input   1  one-clk strobe; host has consumed rx_data
  rx_data    output  8  last completed byte, LSB received first
  rda        output  1  receive data available
  frame_err  output  1  stop bit of last byte sampled low
  overrun    output  1  byte completed while rda already set
REQ-002 There is one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-003 rxd SHALL pass through a 2-flop synchronizer (flops reset to 1) before any use; the synchronized value is rxd_s.
REQ-004 Oversample counter tick_cnt (4 bits) and bit counter bit_cnt (3 bits) SHALL change only on cycles with baud=1, except the clears in REQ-006.
REQ-005 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-006 IDLE: a falling edge on rxd_s (previous 1, current 0) SHALL clear tick_cnt and go to START, independent of baud.
REQ-007 START: when tick_cnt reaches 7 on a baud cycle, rxd_s is sampled: 0 clears tick_cnt and bit_cnt and goes to DATA; 1 is a false start and returns to IDLE without touching outputs.
REQ-008 DATA: when tick_cnt reaches 15 on a baud cycle (tick_cnt then wraps to 0), rxd_s SHALL be shifted into bit 7 of the shift register (right shift, LSB first) and bit_cnt incremented; after the 8th sample (bit_cnt=7) the FSM goes to STOP.
REQ-009 STOP: when tick_cnt reaches 15 on a baud cycle, the shift register SHALL load into rx_data, rda set, frame_err set to the inverse of rxd_s, and the FSM returns to IDLE in the same cycle.
REQ-010 A byte SHALL be loaded into rx_data whether or not the stop bit is valid.
REQ-011 If rda=1 when a byte completes, rx_data SHALL be overwritten and overrun set.
REQ-012 rd_ack SHALL clear rda, frame_err and overrun on the next edge.
REQ-013 If rd_ack and byte completion occur in the same cycle, completion SHALL win: rda=1, frame_err per the new stop bit, overrun=0.
REQ-014 A falling edge in IDLE SHALL be detected on the cycle immediately after STOP completes, so back-to-back frames are received without loss.
REQ-015 A line held low after a framing error SHALL NOT start a new frame until rxd_s has returned high and fallen again.
REQ-016 Outputs SHALL be registered; rx_data is stable while rda=1 unless overrun occurs.

Reset
REQ-017 On rst_n=0: FSM=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, rx_data=8'h00, rda=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-018 Reset mid-frame SHALL abandon the frame; after release the next falling edge starts a fresh frame.

Structure
REQ-019 Package spart_pkg SHALL hold the state enum, OVERSAMPLE=16, SAMPLE_MID=7 and DATA_BITS=8; the transmitter imports the same package.
REQ-020 One sub-module, spart_sync2 (2-flop synchronizer, parameterized reset value), SHALL be instantiated for rxd.

Verification
REQ-021 Bench SHALL drive baud as a 1-in-4-clk pulse (fast mode) and one run SHALL use the real generator (divisor 16'h0145).
REQ-022 Scenarios:
  - Frame 0x55, stop=1 -> rda=1, rx_data=8'h55, frame_err=0 in the cycle after the 16th stop tick; rd_ack -> rda=0.
  - Frames 0xA3 then 0x0F back-to-back, no idle gap, rd_ack after each -> both bytes correct, overrun=0.
  - Low glitch of 3 baud ticks on idle line -> false start, no rda, FSM back in IDLE.
  - Frame 0x81 with stop bit 0 -> rx_data=8'h81, rda=1, frame_err=1; line held low -> no new frame.
  - Two frames, no rd_ack -> rx_data=second byte, overrun=1; rd_ack coincident with third completion -> rda=1, overrun=0.
  - rst_n pulsed mid-DATA -> all outputs 0; following frame 0x3C received correctly.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART receiver and transmitter: FSM encoding,
// oversampling ratio and derived counter widths/limits.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } spart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;
    localparam int DATA_BITS  = 8;

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(SAMPLE_MID);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

endpackage

// File: rtl/spart_rx_if.sv
// Host-side signal bundle of the SPART receiver: baud enable, serial line,
// read strobe and the registered status/data returned to the host.
interface spart_rx_if;
    import spart_pkg::*;

    logic                 baud;
    logic                 rxd;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output baud, rxd, rd_ack,
        input  rx_data, rda, frame_err, overrun
    );

    modport slave (
        input  baud, rxd, rd_ack,
        output rx_data, rda, frame_err, overrun
    );
endinterface

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset to
// RST_VAL so the synchronized output never glitches out of reset.
module spart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: flops take non-blocking assignments so every stage samples the
    // value from before the edge; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 deserializer with start-bit validation,
// framing-error and overrun status, and a one-strobe host acknowledge.
module spart_rx
    import spart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud,
    input  logic                 rxd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun
);

    spart_rx_if host ();

    assign host.baud   = baud;
    assign host.rxd    = rxd;
    assign host.rd_ack = rd_ack;
    assign rx_data     = host.rx_data;
    assign rda         = host.rda;
    assign frame_err   = host.frame_err;
    assign overrun     = host.overrun;

    logic rxd_s;

    spart_sync2 #(.RST_VAL(1'b1)) u_rxd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (host.rxd),
        .q     (rxd_s)
    );

    spart_state_e         state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rxd_prev_q, rxd_prev_d;
    logic                 rda_q, rda_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic fall_edge;
    logic mid_hit;
    logic last_hit;
    logic byte_done;

    assign fall_edge = rxd_prev_q & ~rxd_s;
    assign mid_hit   = host.baud && (tick_q == TICK_MID);
    assign last_hit  = host.baud && (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d defaults to the current state before the case so every
    // path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fall_edge) state_d = START;
            START: if (mid_hit)   state_d = rxd_s ? IDLE : DATA;
            DATA:  if (last_hit && (bit_q == BIT_LAST)) state_d = STOP;
            STOP:  if (last_hit)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall_edge) tick_d = '0;
            end
            START: begin
                if (mid_hit && !rxd_s) begin
                    tick_d = '0;
                    bit_d  = '0;
                end else if (host.baud) begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (host.baud) tick_d = tick_q + TICK_W'(1);
                // LSB arrives first, so each new bit enters at the top.
                if (last_hit) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                end
            end
            STOP: begin
                if (host.baud) tick_d = tick_q + TICK_W'(1);
                byte_done = last_hit;
            end
            default: begin
                tick_d = '0;
            end
        endcase

        rxd_prev_d  = rxd_s;
        rx_data_d   = byte_done ? shift_q : rx_data_q;
        // A completing byte outranks a same-cycle acknowledge.
        rda_d       = byte_done | (rda_q & ~host.rd_ack);
        frame_err_d = byte_done ? ~rxd_s : (frame_err_q & ~host.rd_ack);
        overrun_d   = byte_done ? (rda_q & ~host.rd_ack)
                                : (overrun_q & ~host.rd_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rxd_prev_q  <= 1'b1;
            rda_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rxd_prev_q  <= rxd_prev_d;
            rda_q       <= rda_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign host.rx_data   = rx_data_q;
    assign host.rda       = rda_q;
    assign host.frame_err = frame_err_q;
    assign host.overrun   = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: frames are serialized against the baud
// enable, expected bytes/status are queued at send time and popped on completion.
module tb_spart_rx;
    import spart_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   baud_div = 4;
    int   baud_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   model_rda = 1'b0;
    exp_t sb_q[$];

    spart_rx_if bus ();

    spart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud      (bus.baud),
        .rxd       (bus.rxd),
        .rd_ack    (bus.rd_ack),
        .rx_data   (bus.rx_data),
        .rda       (bus.rda),
        .frame_err (bus.frame_err),
        .overrun   (bus.overrun)
    );

    always #5 clk = ~clk;

    // Divisor-based baud enable: one-clk pulse every baud_div clocks.
    always @(posedge clk) begin
        if (baud_cnt >= baud_div - 1) begin
            baud_cnt <= 0;
            bus.baud <= 1'b1;
        end else begin
            baud_cnt <= baud_cnt + 1;
            bus.baud <= 1'b0;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // Returns 1 time unit after the n-th baud-enabled edge.
    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (bus.baud !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        tick_wait(n);
    endtask

    task automatic do_ack();
        bus.rd_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_ack = 1'b0;
        model_rda = 1'b0;
        n_total++;
        if (bus.rda !== 1'b0) $display("FAIL ack_rda: got %b want 0", bus.rda);
        else n_pass++;
        n_total++;
        if (bus.frame_err !== 1'b0) $display("FAIL ack_frame_err: got %b want 0", bus.frame_err);
        else n_pass++;
        n_total++;
        if (bus.overrun !== 1'b0) $display("FAIL ack_overrun: got %b want 0", bus.overrun);
        else n_pass++;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input bit ack_at_done, input bit ack_after);
        exp_t e;
        exp_t got;
        e.data = data;
        e.fe   = ~stop;
        e.ov   = model_rda && !ack_at_done;
        sb_q.push_back(e);

        bus.rxd = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = data[i];
            tick_wait(16);
        end
        bus.rxd = stop;
        tick_wait(7);

        n_total++;
        if (bus.rda !== model_rda)
            $display("FAIL early_rda(%h): got %b want %b one tick before stop sample", data, bus.rda, model_rda);
        else n_pass++;

        repeat (baud_div - 1) @(posedge clk);
        #1;
        bus.rd_ack = ack_at_done;
        @(posedge clk);
        #1;
        bus.rd_ack = 1'b0;
        model_rda = 1'b1;

        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: empty at completion of %h", data);
        end else begin
            got = sb_q.pop_front();
            n_total++;
            if (bus.rda !== 1'b1) $display("FAIL done_rda(%h): got %b want 1", got.data, bus.rda);
            else n_pass++;
            n_total++;
            if (bus.rx_data !== got.data) $display("FAIL done_rx_data: got %h want %h", bus.rx_data, got.data);
            else n_pass++;
            n_total++;
            if (bus.frame_err !== got.fe) $display("FAIL done_frame_err(%h): got %b want %b", got.data, bus.frame_err, got.fe);
            else n_pass++;
            n_total++;
            if (bus.overrun !== got.ov) $display("FAIL done_overrun(%h): got %b want %b", got.data, bus.overrun, got.ov);
            else n_pass++;
        end

        if (ack_after) do_ack();
        tick_wait(8);
    endtask

    task automatic test_reset();
        bus.rxd = 1'b1;
        bus.rd_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", bus.rx_data);
        else n_pass++;
        n_total++;
        if ({bus.rda, bus.frame_err, bus.overrun} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus.rda, bus.frame_err, bus.overrun});
        else n_pass++;
        n_total++;
        if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        else n_pass++;
        rst_n = 1'b1;
        model_rda = 1'b0;
        idle(8);
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        do_ack();
        idle(4);
    endtask

    task automatic test_back_to_back();
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
        idle(4);
    endtask

    task automatic test_false_start();
        bus.rxd = 1'b0;
        tick_wait(3);
        bus.rxd = 1'b1;
        tick_wait(12);
        n_total++;
        if (dut.state_q !== IDLE) $display("FAIL glitch_state: got %0d want IDLE", dut.state_q);
        else n_pass++;
        n_total++;
        if (bus.rda !== 1'b0) $display("FAIL glitch_rda: got %b want 0", bus.rda);
        else n_pass++;
        idle(8);
    endtask

    task automatic test_frame_err();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        bus.rxd = 1'b0;
        tick_wait(200);
        n_total++;
        if (dut.state_q !== IDLE) $display("FAIL held_low_state: got %0d want IDLE", dut.state_q);
        else n_pass++;
        n_total++;
        if ({bus.rda, bus.frame_err, bus.overrun} !== 3'b110)
            $display("FAIL held_low_flags: got %b want 110", {bus.rda, bus.frame_err, bus.overrun});
        else n_pass++;
        n_total++;
        if (bus.rx_data !== 8'h81) $display("FAIL held_low_rx_data: got %h want 81", bus.rx_data);
        else n_pass++;
        do_ack();
        idle(20);
    endtask

    task automatic test_overrun();
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0);
        send_frame(8'h56, 1'b1, 1'b1, 1'b0);
        do_ack();
        idle(4);
    endtask

    task automatic test_reset_mid();
        logic [7:0] partial;
        partial = 8'hC5;
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        bus.rxd = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 3; i++) begin
            bus.rxd = partial[i];
            tick_wait(16);
        end
        rst_n = 1'b0;
        bus.rxd = 1'b1;
        #20;
        n_total++;
        if ({bus.rx_data, bus.rda, bus.frame_err, bus.overrun} !== 11'h000)
            $display("FAIL midreset_outputs: got %h/%b%b%b want 00/000", bus.rx_data, bus.rda, bus.frame_err, bus.overrun);
        else n_pass++;
        n_total++;
        if (dut.state_q !== IDLE) $display("FAIL midreset_state: got %0d want IDLE", dut.state_q);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_rda = 1'b0;
        idle(20);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(4);
    endtask

    task automatic test_real_baud();
        baud_div = 16'h0145;
        idle(2);
        send_frame(8'hE7, 1'b1, 1'b0, 1'b1);
        baud_div = 4;
        idle(2);
    endtask

    initial begin
        bus.rxd = 1'b1;
        bus.rd_ack = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_real_baud();
        n_total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
